// File: rtl/hexbs_mc_recon_if.sv
// Bundle of request, reference-read, residual-stream, write and status signals
// for the motion-compensated macroblock reconstructor.
interface hexbs_mc_recon_if;
  logic              start;
  logic [31:0]       ref_start_addr;
  logic [31:0]       recon_start_addr;
  logic [31:0]       mb_x_pos;
  logic [31:0]       mb_y_pos;
  logic signed [5:0] mv_x;
  logic signed [5:0] mv_y;

  logic [31:0]       mem_addr;
  logic [7:0]        mem_rdata;

  logic              res_valid;
  logic signed [8:0] res_data;
  logic              res_ready;

  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [7:0]        wr_data;

  logic              busy;
  logic              done;

  modport slave (
    input  start, ref_start_addr, recon_start_addr, mb_x_pos, mb_y_pos, mv_x, mv_y,
    input  mem_rdata, res_valid, res_data,
    output mem_addr, res_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport master (
    output start, ref_start_addr, recon_start_addr, mb_x_pos, mb_y_pos, mv_x, mv_y,
    output mem_rdata, res_valid, res_data,
    input  mem_addr, res_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/hexbs_mc_recon.sv
// Reconstructs one macroblock: fetches edge-replicated motion-compensated reference
// pixels, adds the raster-order residual stream and writes saturated results.
module hexbs_mc_recon #(
  parameter int FRAME_WIDTH  = 352,
  parameter int FRAME_HEIGHT = 240,
  parameter int MB_SIZE      = 16
) (
  input  logic           clk,
  input  logic           rst,
  hexbs_mc_recon_if.slave bus
);

  localparam int CW = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
  localparam logic [CW-1:0]       C_LAST = CW'(MB_SIZE - 1);
  localparam logic signed [39:0]  MB_S   = 40'(MB_SIZE);
  localparam logic signed [39:0]  X_MAX  = 40'(FRAME_WIDTH - 1);
  localparam logic signed [39:0]  Y_MAX  = 40'(FRAME_HEIGHT - 1);
  localparam logic [31:0]         FW32   = 32'(FRAME_WIDTH);
  localparam logic [31:0]         MB32   = 32'(MB_SIZE);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]       ref_q, recon_q, mbx_q, mby_q;
  logic signed [5:0] mvx_q, mvy_q;
  logic [CW-1:0]     r_q, c_q;

  logic              accept, hs, last_hs;
  logic signed [39:0] x_lin, y_lin;
  logic [31:0]       rx, ry, wr_addr_c;
  logic signed [9:0] pix_sum;
  logic [7:0]        pix_sat;

  assign accept  = (state_q == IDLE) && bus.start;
  assign hs      = (state_q == FETCH) && bus.res_valid;
  assign last_hs = hs && (r_q == C_LAST) && (c_q == C_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FETCH;
      FETCH:   if (last_hs)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured request fields are plain data registers with no reset; they
  // are only consumed after a start reloads them, so a reset term would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      ref_q   <= bus.ref_start_addr;
      recon_q <= bus.recon_start_addr;
      mbx_q   <= bus.mb_x_pos;
      mby_q   <= bus.mb_y_pos;
      mvx_q   <= bus.mv_x;
      mvy_q   <= bus.mv_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
    end else if (accept) begin
      r_q <= '0;
      c_q <= '0;
    end else if (hs) begin
      if (c_q == C_LAST) begin
        c_q <= '0;
        r_q <= r_q + 1'b1;
      end else begin
        c_q <= c_q + 1'b1;
      end
    end
  end

  // Reference coordinates are formed wide and signed so MV underflow and frame-edge
  // overflow both clamp, replicating the border pixels.
  always_comb begin
    x_lin = $signed({8'd0, mbx_q}) * MB_S + $signed({{(40-CW){1'b0}}, c_q}) + 40'(mvx_q);
    y_lin = $signed({8'd0, mby_q}) * MB_S + $signed({{(40-CW){1'b0}}, r_q}) + 40'(mvy_q);

    if (x_lin < 0)          rx = '0;
    else if (x_lin > X_MAX) rx = X_MAX[31:0];
    else                    rx = x_lin[31:0];

    if (y_lin < 0)          ry = '0;
    else if (y_lin > Y_MAX) ry = Y_MAX[31:0];
    else                    ry = y_lin[31:0];

    bus.mem_addr = (state_q == FETCH) ? (ref_q + ry * FW32 + rx) : 32'd0;
  end

  always_comb begin
    pix_sum = $signed({2'b00, bus.mem_rdata}) + 10'(bus.res_data);
    if (pix_sum < 0)            pix_sat = 8'd0;
    else if (pix_sum > 10'sd255) pix_sat = 8'd255;
    else                        pix_sat = pix_sum[7:0];

    wr_addr_c = recon_q + (mby_q * MB32 + 32'(r_q)) * FW32 + mbx_q * MB32 + 32'(c_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= hs;
      if (hs) begin
        bus.wr_addr <= wr_addr_c;
        bus.wr_data <= pix_sat;
      end
    end
  end

  assign bus.res_ready = (state_q == FETCH);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_hexbs_mc_recon.sv
// Directed self-checking bench for hexbs_mc_recon: flat, gradient, clamped-edge,
// saturation, throttled-stream and abort scenarios with hand-derived expectations.
module tb_hexbs_mc_recon;
  localparam int FW = 352;
  localparam int FH = 240;
  localparam int MB = 16;
  localparam logic [31:0] REF_BASE   = 32'h1000_0000;
  localparam logic [31:0] RECON_BASE = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hexbs_mc_recon_if bus ();

  hexbs_mc_recon #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .MB_SIZE     (MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  bit                flat_mode;
  logic [7:0]        flat_val;
  logic signed [8:0] res_const;
  int g_mbx, g_mby, g_mvx, g_mvy;

  int          nw, nd;
  logic [7:0]  first_wd, last_wd;
  logic [31:0] first_rd, last_rd, first_wa;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: either a flat level or the (x+y)&255 gradient, decoded from address.
  function automatic logic [7:0] ref_pix(input logic [31:0] addr, input bit flat, input logic [7:0] fv);
    int off;
    off = int'(addr - REF_BASE);
    if (flat) return fv;
    return 8'((off % FW) + (off / FW));
  endfunction

  assign bus.mem_rdata = ref_pix(bus.mem_addr, flat_mode, flat_val);

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int px(input int k);
    return clampi(g_mbx * MB + k % MB + g_mvx, FW - 1);
  endfunction

  function automatic int py(input int k);
    return clampi(g_mby * MB + k / MB + g_mvy, FH - 1);
  endfunction

  function automatic logic [31:0] exp_rd(input int k);
    return REF_BASE + 32'(py(k) * FW + px(k));
  endfunction

  function automatic logic [31:0] exp_wa(input int k);
    return RECON_BASE + 32'((g_mby * MB + k / MB) * FW + g_mbx * MB + k % MB);
  endfunction

  function automatic logic [31:0] exp_wd(input int k);
    int p;
    p = flat_mode ? int'(flat_val) : ((px(k) + py(k)) & 255);
    return 32'(clampi(p + int'(res_const), 255));
  endfunction

  // Issues one MB request starting in the current cycle and monitors it to completion.
  task automatic run_mb(input int mbx, input int mby, input int mvx, input int mvy,
                        input bit alt, input int abort_at, input bit poke, input bit mid_start);
    bit finished, aborted, timed, hs_now;
    int hs, post;
    g_mbx = mbx; g_mby = mby; g_mvx = mvx; g_mvy = mvy;
    nw = 0; nd = 0; hs = 0; post = 0;
    finished = 1'b0; aborted = 1'b0;
    timed = !alt && (abort_at == 0);
    bus.mb_x_pos = 32'(mbx);
    bus.mb_y_pos = 32'(mby);
    bus.mv_x     = 6'(mvx);
    bus.mv_y     = 6'(mvy);
    bus.res_data = res_const;
    bus.res_valid = !alt;
    bus.start    = 1'b1;
    for (int cyc = 0; cyc < 700 && !finished; cyc++) begin
      @(negedge clk);
      hs_now = bus.res_valid && bus.res_ready;
      if (hs_now) begin
        check("rd_addr", bus.mem_addr, exp_rd(hs));
        if (hs == 0) first_rd = bus.mem_addr;
        last_rd = bus.mem_addr;
      end
      if (bus.wr_en) begin
        check("wr_addr", bus.wr_addr, exp_wa(nw));
        check("wr_data", 32'(bus.wr_data), exp_wd(nw));
        if (timed) check("wr_cycle", cyc, nw + 2);
        if (nw == 0) begin
          first_wd = bus.wr_data;
          first_wa = bus.wr_addr;
        end
        last_wd = bus.wr_data;
        nw++;
      end
      if (bus.done) begin
        nd++;
        check("done_with_last_wr", {bus.wr_en, nw == 256}, 32'd3);
        if (timed) check("done_cycle", cyc, 257);
        finished = 1'b1;
        if (poke) bus.start = 1'b1;
      end
      if (aborted) begin
        post++;
        if (post == 1) begin
          check("abort_busy", bus.busy, 0);
          check("abort_ready", bus.res_ready, 0);
          check("abort_mem_addr", bus.mem_addr, 0);
          check("abort_wr_addr", bus.wr_addr, 0);
          check("abort_wr_data", 32'(bus.wr_data), 0);
        end
        if (post == 20) finished = 1'b1;
      end else if (abort_at != 0 && nw == abort_at) begin
        rst = 1'b1;
        aborted = 1'b1;
      end
      if (mid_start && cyc == 50) begin
        bus.start    = 1'b1;
        bus.mb_x_pos = 32'd0;
        bus.mv_x     = 6'd0;
      end
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.mb_x_pos = 32'(mbx);
      bus.mv_x     = 6'(mvx);
      if (hs_now) hs++;
      bus.res_valid = alt ? (((cyc + 1) % 2) == 1) : 1'b1;
    end
    check("finished_in_budget", finished, 1);
    check("n_writes", nw, (abort_at != 0) ? abort_at : 256);
    check("n_done", nd, (abort_at != 0) ? 0 : 1);
    if (poke) check("start_in_done_ignored", bus.busy, 0);
    bus.res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ref_start_addr   = REF_BASE;
    bus.recon_start_addr = RECON_BASE;
    bus.mb_x_pos = '0; bus.mb_y_pos = '0;
    bus.mv_x = '0; bus.mv_y = '0;
    bus.res_valid = 1'b0; bus.res_data = '0;
    flat_mode = 1'b1; flat_val = 8'd100; res_const = 9'sd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.res_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);

    // Reset and start together: reset wins.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_over_start", bus.busy, 0);
    @(posedge clk); #1;

    // Flat reference 100, zero residual, start pulsed again during done.
    run_mb(10, 10, 0, 0, 1'b0, 0, 1'b1, 1'b0);
    check("flat_first_wa", first_wa, RECON_BASE + 32'd56480);
    check("flat_first_wd", 32'(first_wd), 100);

    // Gradient reference with positive MV, started in the first IDLE cycle after done.
    flat_mode = 1'b0;
    run_mb(10, 10, 5, 3, 1'b0, 0, 1'b0, 1'b0);
    check("grad_first_wd", 32'(first_wd), 72);
    check("grad_last_wd", 32'(last_wd), 102);

    run_mb(0, 0, -8, -8, 1'b0, 0, 1'b0, 1'b0);
    check("tl_clamp_rd", first_rd, REF_BASE);
    check("tl_clamp_wd", 32'(first_wd), 0);

    run_mb(21, 14, 31, 31, 1'b0, 0, 1'b0, 1'b0);
    check("br_clamp_first_rd", first_rd, REF_BASE + 32'd84479);
    check("br_clamp_last_rd", last_rd, REF_BASE + 32'd84479);
    check("br_clamp_wd", 32'(first_wd), 78);

    flat_mode = 1'b1;
    flat_val = 8'd250; res_const = 9'sd20;
    run_mb(1, 1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    check("sat_high", 32'(first_wd), 255);
    flat_val = 8'd5; res_const = -9'sd20;
    run_mb(1, 1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    check("sat_low", 32'(first_wd), 0);
    flat_val = 8'd255; res_const = -9'sd256;
    run_mb(1, 1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    check("sat_min_res", 32'(first_wd), 0);

    // Throttled stream with a start pulse and changed inputs mid-block.
    flat_mode = 1'b0; res_const = 9'sd7;
    run_mb(3, 2, -2, 4, 1'b1, 0, 1'b0, 1'b1);

    // Abort after 100 writes, then a fresh block completes.
    res_const = 9'sd0;
    run_mb(5, 5, 1, 1, 1'b0, 100, 1'b0, 1'b0);
    run_mb(6, 7, -1, 2, 1'b0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hexbs_mc_recon.md
HEXBS_MC_RECON -- requirements
Module: hexbs_mc_recon

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 352, luma frame width in pixels.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 240, luma frame height in pixels.
REQ-003 SHALL have parameter MB_SIZE, default 16, macroblock edge in pixels.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to reconstruct one MB.
REQ-007 SHALL have port ref_start_addr  input  32  reference frame base byte address.
REQ-008 SHALL have port recon_start_addr  input  32  reconstructed frame base byte address.
REQ-009 SHALL have ports mb_x_pos, mb_y_pos  input  32 each  MB column and row index.
REQ-010 SHALL have ports mv_x, mv_y  input  6 each, signed  motion vector in pixels, range -32..+31.
REQ-011 SHALL have port mem_addr  output  32  reference read address.
REQ-012 SHALL have port mem_rdata  input  8  reference pixel, combinational same-cycle return for mem_addr.
REQ-013 SHALL have ports res_valid  input  1; res_data  input  9, signed  residual stream in raster order.
REQ-014 SHALL have port res_ready  output  1  residual accept.
REQ-015 SHALL have ports wr_en  output  1; wr_addr  output  32; wr_data  output  8  reconstructed pixel write.
REQ-016 SHALL have ports busy  output  1; done  output  1  status.

Function
REQ-017 SHALL implement FSM IDLE -> FETCH -> DONE -> IDLE.
REQ-018 In IDLE, start=1 SHALL latch all address, position and MV inputs, clear row/col counters r,c, and enter FETCH next cycle; start outside IDLE SHALL be ignored.
REQ-019 In FETCH, mem_addr SHALL equal ref_start_addr + ry*FRAME_WIDTH + rx, where rx = clamp(mb_x_pos*MB_SIZE + c + mv_x, 0, FRAME_WIDTH-1) and ry = clamp(mb_y_pos*MB_SIZE + r + mv_y, 0, FRAME_HEIGHT-1) (edge replication).
REQ-020 Outside FETCH, mem_addr SHALL be 0.
REQ-021 res_ready SHALL be 1 exactly in FETCH; a handshake is res_valid & res_ready.
REQ-022 On each handshake, the next cycle SHALL drive wr_en=1, wr_data = clamp(mem_rdata + res_data, 0, 255) using 10-bit signed arithmetic, and wr_addr = recon_start_addr + (mb_y_pos*MB_SIZE + r)*FRAME_WIDTH + mb_x_pos*MB_SIZE + c; otherwise wr_en SHALL be 0.
REQ-023 After each handshake, c SHALL increment and wrap from MB_SIZE-1 to 0 with r incrementing; no handshake leaves r,c unchanged.
REQ-024 The handshake at r=c=MB_SIZE-1 SHALL move the FSM to DONE.
REQ-025 DONE SHALL last exactly one cycle, assert done=1 coincident with the final wr_en, then return to IDLE.
REQ-026 busy SHALL be 1 in FETCH and DONE, 0 in IDLE.
REQ-027 With res_valid held high, start at cycle 0 SHALL give handshakes in cycles 1..256, wr_en in cycles 2..257, and done in cycle 257.
REQ-028 start asserted in the cycle done=1 SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-029 rst=1 SHALL force, on the next clock edge, state IDLE, r=c=0, and outputs mem_addr=0, res_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-030 rst during FETCH SHALL abort the MB; no further wr_en and no done SHALL occur for that MB.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 Flat ref=100, MB(10,10), MV(0,0), res=0 held valid -> 256 writes of 100 to recon_start_addr + (160+r)*352 + 160+c, done in cycle 257 only.
REQ-033 Ref pixel = (x+y)&255, MB(10,10), MV(+5,+3), res=0 -> first wr_data=72 at (160,160), last wr_data=(180+178)&255=102.
REQ-034 Same pattern, MB(0,0), MV(-8,-8) -> pixel (0,0) reads ref addr ref_start_addr+0 and outputs 0; MB(21,14), MV(+31,+31) -> every read clamps to x=351, y=239.
REQ-035 Saturation: ref 250 with res +20 -> 255; ref 5 with res -20 -> 0; ref 255 with res -256 -> 0.
REQ-036 res_valid alternating 1,0 starting in cycle 1 -> exactly 256 writes in raster order, no duplicates or skips; done coincides with the final write.
REQ-037 rst asserted after the 100th write, then a new start -> no done for the aborted MB; the new MB completes with 256 writes and done.
